bowling_frame_ctrl: RTL and testbench
=====================================

// Module: bowling_frame_ctrl
// PURPOSE
//  Sequences one bowling game over the NPINS pin FSMs: clears pins, waits for a throw, waits for settle,
//  tallies knocked pins, advances roll/frame and keeps the running score with strike/spare bonus.
//  Sits between the throw input logic (aim/power capture, one-second tick) and the pinFSM array.
// PARAMETERS
//  NPINS        10  pins per rack; drives the width of pin_hit and the 4-bit count
//  SETTLE_TICKS 2   tick pulses waited after throw_req before sampling pin_hit (1..7)
//  CLR_CYC      4   CLOCK_50 cycles pin_clr_n is held low per clear (1..15)
// PORTS
//  CLOCK_50   in   1      system clock
//  reset      in   1      asynchronous, active-low reset
//  tick       in   1      one-cycle one-second enable
//  throw_req  in   1      one-cycle pulse: ball released (aim/power are stable)
//  pin_hit    in   NPINS  hit outputs of the pin FSMs
//  pin_clr_n  out  1      active-low clear to all pin FSMs
//  ready      out  1      high while waiting for throw_req
//  frame      out  4      current frame, 1..10
//  roll       out  2      roll in frame: 0, 1, 2 (2 = fill ball)
//  roll_pins  out  4      pins knocked by last tallied roll
//  down_mask  out  NPINS  pins down in the current rack
//  strike     out  1      last tallied roll was a strike (held until next tally)
//  spare      out  1      last tallied roll was a spare (held until next tally)
//  score      out  9      running score, 0..300
//  game_over  out  1      final roll tallied
// BEHAVIOUR
//  Reset (async, reset low): state CLEAR, pin_clr_n=0, ready=0, frame=1, roll=0, roll_pins=0,
//   down_mask=0, strike=0, spare=0, score=0, game_over=0, bonus slots empty, clear count=0.
//  States:
//   CLEAR : pin_clr_n=0 for CLR_CYC cycles, then READY. Does not touch down_mask.
//   READY : ready=1. throw_req -> SETTLE with tick count=0. Other inputs ignored.
//   SETTLE: count tick pulses. On the SETTLE_TICKS-th tick -> TALLY.
//           throw_req is ignored. tick on the entry cycle does not count.
//   TALLY : 1 cycle. new = pin_hit & ~down_mask. roll_pins = popcount(new).
//           down_mask |= new. Score update as below. -> ADVANCE.
//   ADVANCE: 1 cycle. Rack full or roll done -> down_mask=0, next roll/frame -> CLEAR.
//            Game end -> DONE.
//   DONE  : game_over=1, pin_clr_n=1, all outputs hold until reset.
//  Roll rules, frames 1..9: strike on roll 0 -> next frame. Otherwise roll 1 follows; after roll 1 -> next frame.
//  Strike = roll 0 with down_mask == all ones. Spare = roll 1 completing the rack.
//  Score: two bonus slots, each holding a remaining count (0..2).
//   Increment = roll_pins * (base + number of slots with count>0). base=1, except fill balls where base=0.
//   Every non-zero slot then decrements.
//   A strike loads a free slot with 2; a spare loads it with 1. Never more than 2 slots are live.
//   Fill balls never load a slot.
//  Score width: 9 bits is enough; the maximum is 300, so there is no wrap.
//  Pins already down before a roll are masked, so a stuck pin_hit never double-counts.
//  Reset in any state aborts at once to the reset values. A partial frame is discarded.
// CONFIGURATION
//  TENTH_FILL_EN defined:
//   Frame 10 strike on roll 0, or spare on roll 1, grants fill balls (roll=2 state, base 0).
//   Strike -> two fill rolls. down_mask is cleared after any strike or after roll 1 completes the rack.
//   Spare -> one fill roll.
//   Game ends after the last granted roll.
//  TENTH_FILL_EN undefined:
//   Frame 10 behaves like frames 1..9. Game ends when frame 10 completes.
//   Unconsumed bonus slots are dropped. Maximum score is 270.
// TESTING
//  1 Every roll has pin_hit=0 (20 rolls) -> roll_pins=0 each roll, score=0, game_over after frame 10 roll 1.
//  2 Frame 1: 7 pins then 3 more (spare, spare=1); frame 2: 4 then 0 -> score 14 after frame 1 bonus, 18 after frame 2.
//  3 12 strikes with TENTH_FILL_EN -> score 300, strike=1 each roll, game_over=1, frame=10, roll=2.
//    Without the macro: 10 strikes -> score 270.
//  4 Roll 0 hits pins 0-4; roll 1 pin_hit stays 0x3FF -> roll 1 roll_pins=5 (masked), spare=1.
//  5 throw_req during SETTLE plus a tick on the entry cycle -> tally exactly SETTLE_TICKS ticks later.
//    Second throw_req ignored.
//  6 reset low mid-SETTLE in frame 5 -> frame=1, score=0, pin_clr_n=0 immediately.
//    CLR_CYC cycles after release -> ready=1.

Source files
------------

// File: rtl/bowling_frame_ctrl.sv
// Bowling game sequencer: clears the pin rack, waits for a throw and settle ticks, tallies pins and keeps score.
// Optional macro TENTH_FILL_EN enables tenth-frame fill balls; when undefined, frame 10 plays like frames 1..9.
module bowling_frame_ctrl #(
    parameter int NPINS        = 10,
    parameter int SETTLE_TICKS = 2,
    parameter int CLR_CYC      = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             tick,
    input  logic             throw_req,
    input  logic [NPINS-1:0] pin_hit,
    output logic             pin_clr_n,
    output logic             ready,
    output logic [3:0]       frame,
    output logic [1:0]       roll,
    output logic [3:0]       roll_pins,
    output logic [NPINS-1:0] down_mask,
    output logic             strike,
    output logic             spare,
    output logic [8:0]       score,
    output logic             game_over
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_READY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_TALLY   = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] CLR_LAST    = 4'(CLR_CYC - 1);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_TICKS - 1);

    state_t           state_q, state_d;
    logic [3:0]       clr_cnt_q, clr_cnt_d;
    logic [2:0]       tick_cnt_q, tick_cnt_d;
    logic             entry_q, entry_d;
    logic             pin_clr_n_q, pin_clr_n_d;
    logic             ready_q, ready_d;
    logic [3:0]       frame_q, frame_d;
    logic [1:0]       roll_q, roll_d;
    logic [3:0]       roll_pins_q, roll_pins_d;
    logic [NPINS-1:0] down_mask_q, down_mask_d;
    logic             strike_q, strike_d;
    logic             spare_q, spare_d;
    logic [8:0]       score_q, score_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       slot_a_q, slot_a_d;
    logic [1:0]       slot_b_q, slot_b_d;
`ifdef TENTH_FILL_EN
    logic [1:0]       fill_left_q, fill_left_d;
`endif

    function automatic logic [3:0] popcount(input logic [NPINS-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NPINS; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [1:0] slot_dec(input logic [1:0] s);
        return (s == 2'd0) ? 2'd0 : s - 2'd1;
    endfunction

    logic [NPINS-1:0] new_pins;
    logic [NPINS-1:0] mask_after;
    logic [3:0]       new_cnt;
    logic             full_after;
    logic             is_fill;
    logic             strike_now;
    logic             spare_now;
    logic [1:0]       live_slots;
    logic [1:0]       mult;
    logic [1:0]       slot_a_dec;
    logic [1:0]       slot_b_dec;
    logic             rack_full;
    logic             last_frame;

    // Pins already down are masked so a stuck pin_hit never counts twice.
    assign new_pins   = pin_hit & ~down_mask_q;
    assign mask_after = down_mask_q | new_pins;
    assign new_cnt    = popcount(new_pins);
    assign full_after = &mask_after;
    assign is_fill    = (roll_q == 2'd2);
    // A fresh rack knocked flat in one ball is a strike; finishing a partial rack is a spare.
    assign strike_now = full_after && (down_mask_q == '0) && (roll_q != 2'd1);
    assign spare_now  = full_after && !strike_now;
    assign live_slots = {1'b0, slot_a_q != 2'd0} + {1'b0, slot_b_q != 2'd0};
    assign mult       = live_slots + (is_fill ? 2'd0 : 2'd1);
    assign slot_a_dec = slot_dec(slot_a_q);
    assign slot_b_dec = slot_dec(slot_b_q);
    assign rack_full  = &down_mask_q;
    assign last_frame = (frame_q == 4'd10);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        entry_d     = entry_q;
        pin_clr_n_d = pin_clr_n_q;
        ready_d     = ready_q;
        frame_d     = frame_q;
        roll_d      = roll_q;
        roll_pins_d = roll_pins_q;
        down_mask_d = down_mask_q;
        strike_d    = strike_q;
        spare_d     = spare_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        slot_a_d    = slot_a_q;
        slot_b_d    = slot_b_q;
`ifdef TENTH_FILL_EN
        fill_left_d = fill_left_q;
`endif

        case (state_q)
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = S_READY;
                    ready_d     = 1'b1;
                    pin_clr_n_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end

            S_READY: begin
                if (throw_req) begin
                    state_d    = S_SETTLE;
                    ready_d    = 1'b0;
                    tick_cnt_d = 3'd0;
                    entry_d    = 1'b1;
                end
            end

            S_SETTLE: begin
                entry_d = 1'b0;
                if (tick && !entry_q) begin
                    if (tick_cnt_q == SETTLE_LAST) begin
                        state_d = S_TALLY;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 3'd1;
                    end
                end
            end

            S_TALLY: begin
                roll_pins_d = new_cnt;
                down_mask_d = mask_after;
                strike_d    = strike_now;
                spare_d     = spare_now;
                score_d     = score_q + ({5'd0, new_cnt} * {7'd0, mult});
                slot_a_d    = slot_a_dec;
                slot_b_d    = slot_b_dec;
                // Fill balls earn bonus from earlier marks but never create new bonus.
                if (!is_fill && (strike_now || spare_now)) begin
                    if (slot_a_dec == 2'd0) begin
                        slot_a_d = strike_now ? 2'd2 : 2'd1;
                    end else begin
                        slot_b_d = strike_now ? 2'd2 : 2'd1;
                    end
                end
                state_d = S_ADVANCE;
            end

            S_ADVANCE: begin
                state_d     = S_CLEAR;
                pin_clr_n_d = 1'b0;
                clr_cnt_d   = 4'd0;
`ifdef TENTH_FILL_EN
                if (last_frame && roll_q == 2'd2) begin
                    fill_left_d = fill_left_q - 2'd1;
                    if (fill_left_q == 2'd1) begin
                        state_d     = S_DONE;
                        game_over_d = 1'b1;
                        pin_clr_n_d = 1'b1;
                    end else if (rack_full) begin
                        down_mask_d = '0;
                    end
                end else if (last_frame && roll_q == 2'd0 && rack_full) begin
                    roll_d      = 2'd2;
                    fill_left_d = 2'd2;
                    down_mask_d = '0;
                end else if (last_frame && roll_q == 2'd1) begin
                    if (rack_full) begin
                        roll_d      = 2'd2;
                        fill_left_d = 2'd1;
                        down_mask_d = '0;
                    end else begin
                        state_d     = S_DONE;
                        game_over_d = 1'b1;
                        pin_clr_n_d = 1'b1;
                    end
                end else
`endif
                if (roll_q == 2'd0 && !rack_full) begin
                    roll_d = 2'd1;
                end else if (last_frame) begin
                    // Any bonus still pending in the slots is simply dropped here.
                    state_d     = S_DONE;
                    game_over_d = 1'b1;
                    pin_clr_n_d = 1'b1;
                end else begin
                    down_mask_d = '0;
                    roll_d      = 2'd0;
                    frame_d     = frame_q + 4'd1;
                end
            end

            S_DONE: begin
                game_over_d = 1'b1;
                pin_clr_n_d = 1'b1;
            end

            default: begin
                state_d     = S_CLEAR;
                pin_clr_n_d = 1'b0;
                clr_cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            clr_cnt_q   <= 4'd0;
            tick_cnt_q  <= 3'd0;
            entry_q     <= 1'b0;
            pin_clr_n_q <= 1'b0;
            ready_q     <= 1'b0;
            frame_q     <= 4'd1;
            roll_q      <= 2'd0;
            roll_pins_q <= 4'd0;
            down_mask_q <= '0;
            strike_q    <= 1'b0;
            spare_q     <= 1'b0;
            score_q     <= 9'd0;
            game_over_q <= 1'b0;
            slot_a_q    <= 2'd0;
            slot_b_q    <= 2'd0;
`ifdef TENTH_FILL_EN
            fill_left_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            entry_q     <= entry_d;
            pin_clr_n_q <= pin_clr_n_d;
            ready_q     <= ready_d;
            frame_q     <= frame_d;
            roll_q      <= roll_d;
            roll_pins_q <= roll_pins_d;
            down_mask_q <= down_mask_d;
            strike_q    <= strike_d;
            spare_q     <= spare_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            slot_a_q    <= slot_a_d;
            slot_b_q    <= slot_b_d;
`ifdef TENTH_FILL_EN
            fill_left_q <= fill_left_d;
`endif
        end
    end

    assign pin_clr_n = pin_clr_n_q;
    assign ready     = ready_q;
    assign frame     = frame_q;
    assign roll      = roll_q;
    assign roll_pins = roll_pins_q;
    assign down_mask = down_mask_q;
    assign strike    = strike_q;
    assign spare     = spare_q;
    assign score     = score_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_bowling_frame_ctrl.sv
// Directed, table-driven bench for bowling_frame_ctrl; follows TENTH_FILL_EN when it is defined.
module tb_bowling_frame_ctrl;

    localparam int NPINS        = 10;
    localparam int SETTLE_TICKS = 2;
    localparam int CLR_CYC      = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             throw_req = 1'b0;
    logic [NPINS-1:0] pin_hit = '0;
    logic             pin_clr_n;
    logic             ready;
    logic [3:0]       frame;
    logic [1:0]       roll;
    logic [3:0]       roll_pins;
    logic [NPINS-1:0] down_mask;
    logic             strike;
    logic             spare;
    logic [8:0]       score;
    logic             game_over;

    bowling_frame_ctrl #(
        .NPINS(NPINS), .SETTLE_TICKS(SETTLE_TICKS), .CLR_CYC(CLR_CYC)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .tick(tick), .throw_req(throw_req),
        .pin_hit(pin_hit), .pin_clr_n(pin_clr_n), .ready(ready), .frame(frame),
        .roll(roll), .roll_pins(roll_pins), .down_mask(down_mask), .strike(strike),
        .spare(spare), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPINS-1:0] hits;
        logic [3:0]       pins;
        logic [8:0]       score;
        logic             strike;
        logic             spare;
        logic [3:0]       frame;
        logic [1:0]       roll;
        logic             done;
    } vec_t;

    vec_t             vecs[$];
    int               n_checks = 0;
    int               n_fail = 0;
    logic [NPINS-1:0] model_dm = '0;

    function automatic void add(input logic [NPINS-1:0] h, input int p, input int s,
                                input bit st, input bit sp, input int f, input int r, input bit d);
        vec_t v;
        v.hits = h; v.pins = 4'(p); v.score = 9'(s); v.strike = st; v.spare = sp;
        v.frame = 4'(f); v.roll = 2'(r); v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; tick = 1'b0; throw_req = 1'b0; pin_hit = '0;
        @(negedge clk);
        reset = 1'b1;
        model_dm = '0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%0d, expected 1 within 200 cycles", ready);
        end
    endtask

    task automatic do_roll(input vec_t v, input int idx);
        wait_ready();
        // A tick coincident with throw_req must not count toward settling.
        pin_hit = v.hits; throw_req = 1'b1; tick = 1'b1;
        @(negedge clk);
        throw_req = 1'b0; tick = 1'b0;
        for (int k = 0; k < SETTLE_TICKS; k++) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
        @(negedge clk);
        model_dm = model_dm | v.hits;
        chk($sformatf("v%0d_roll_pins", idx), 32'(roll_pins), 32'(v.pins));
        chk($sformatf("v%0d_score", idx), 32'(score), 32'(v.score));
        chk($sformatf("v%0d_strike", idx), 32'(strike), 32'(v.strike));
        chk($sformatf("v%0d_spare", idx), 32'(spare), 32'(v.spare));
        chk($sformatf("v%0d_down_mask", idx), 32'(down_mask), 32'(model_dm));
        @(negedge clk);
        chk($sformatf("v%0d_frame", idx), 32'(frame), 32'(v.frame));
        chk($sformatf("v%0d_roll", idx), 32'(roll), 32'(v.roll));
        chk($sformatf("v%0d_game_over", idx), 32'(game_over), 32'(v.done));
        $display("roll %0d: hits=%03h pins=%0d score=%0d strike=%0d spare=%0d -> frame=%0d roll=%0d over=%0d",
                 idx, v.hits, roll_pins, score, strike, spare, frame, roll, game_over);
        if (v.roll == 2'd0 || model_dm == '1) model_dm = '0;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) do_roll(vecs[i], i);
    endtask

    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, n_strikes, sc;

    initial begin
        // Game A: spare bonus, stuck pins masked, strike bonus, then open frames.
        a_lo = vecs.size();
        add(10'h07F,  7,  7, 0, 0, 1, 1, 0);
        add(10'h3FF,  3, 10, 0, 1, 2, 0, 0);
        add(10'h00F,  4, 18, 0, 0, 2, 1, 0);
        add(10'h00F,  0, 18, 0, 0, 3, 0, 0);
        add(10'h01F,  5, 23, 0, 0, 3, 1, 0);
        add(10'h3FF,  5, 28, 0, 1, 4, 0, 0);
        add(10'h3FF, 10, 48, 1, 0, 5, 0, 0);
        add(10'h003,  2, 52, 0, 0, 5, 1, 0);
        add(10'h00F,  2, 56, 0, 0, 6, 0, 0);
        for (int f = 6; f <= 10; f++) begin
            add(10'h000, 0, 56, 0, 0, f, 1, 0);
            add(10'h000, 0, 56, 0, 0, (f == 10) ? 10 : f + 1, (f == 10) ? 1 : 0, f == 10);
        end
        a_hi = vecs.size() - 1;

        // Game B: twenty gutter balls.
        b_lo = vecs.size();
        for (int f = 1; f <= 10; f++) begin
            add(10'h000, 0, 0, 0, 0, f, 1, 0);
            add(10'h000, 0, 0, 0, 0, (f == 10) ? 10 : f + 1, (f == 10) ? 1 : 0, f == 10);
        end
        b_hi = vecs.size() - 1;

        // Game C: all strikes.
`ifdef TENTH_FILL_EN
        n_strikes = 12;
`else
        n_strikes = 10;
`endif
        c_lo = vecs.size();
        for (int n = 1; n <= n_strikes; n++) begin
            sc = (n == 1) ? 10 : (n <= 10) ? 30 * n - 30 : (n == 11) ? 290 : 300;
            if (n <= 9)
                add(10'h3FF, 10, sc, 1, 0, n + 1, 0, 0);
            else if (n == n_strikes)
                add(10'h3FF, 10, sc, 1, 0, 10, (n == 10) ? 0 : 2, 1);
            else
                add(10'h3FF, 10, sc, 1, 0, 10, 2, 0);
        end
        c_hi = vecs.size() - 1;

        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_pin_clr_n", 32'(pin_clr_n), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_frame", 32'(frame), 1);
        chk("rst_roll", 32'(roll), 0);
        chk("rst_roll_pins", 32'(roll_pins), 0);
        chk("rst_down_mask", 32'(down_mask), 0);
        chk("rst_strike", 32'(strike), 0);
        chk("rst_spare", 32'(spare), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_game_over", 32'(game_over), 0);
        @(negedge clk);
        reset = 1'b1;

        run_vectors(a_lo, a_hi);

        do_reset();
        run_vectors(b_lo, b_hi);

        do_reset();
        run_vectors(c_lo, c_hi);
        // Throws and ticks after the game must change nothing.
        throw_req = 1'b1; tick = 1'b1; pin_hit = '0;
        @(negedge clk);
        throw_req = 1'b0;
        repeat (6) @(negedge clk);
        tick = 1'b0;
        chk("done_score_hold", 32'(score), 32'((n_strikes == 12) ? 300 : 270));
        chk("done_game_over", 32'(game_over), 1);
        chk("done_ready", 32'(ready), 0);
        chk("done_pin_clr_n", 32'(pin_clr_n), 1);
        $display("done: score=%0d frame=%0d roll=%0d over=%0d", score, frame, roll, game_over);

        // Entry tick ignored, second throw_req ignored, tally after exactly SETTLE_TICKS ticks.
        do_reset();
        wait_ready();
        pin_hit = 10'h007; throw_req = 1'b1; tick = 1'b1;
        @(negedge clk); throw_req = 1'b0; tick = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0; throw_req = 1'b1;
        @(negedge clk); throw_req = 1'b0;
        chk("t5_no_early_tally", 32'(roll_pins), 0);
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("t5_tally_pending", 32'(roll_pins), 0);
        @(negedge clk);
        chk("t5_tally_pins", 32'(roll_pins), 3);
        chk("t5_tally_score", 32'(score), 3);
        $display("settle: pins=%0d score=%0d", roll_pins, score);

        // Reset mid-settle in frame 5 aborts at once.
        do_reset();
        run_vectors(a_lo, a_lo + 6);
        chk("t6_pre_frame", 32'(frame), 5);
        wait_ready();
        pin_hit = 10'h0F0; throw_req = 1'b1;
        @(negedge clk); throw_req = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_frame", 32'(frame), 1);
        chk("t6_score", 32'(score), 0);
        chk("t6_pin_clr_n", 32'(pin_clr_n), 0);
        chk("t6_ready", 32'(ready), 0);
        @(negedge clk);
        reset = 1'b1;
        model_dm = '0;
        for (int k = 1; k <= CLR_CYC; k++) begin
            @(negedge clk);
            if (k == CLR_CYC - 1) begin
                chk("t6_ready_early", 32'(ready), 0);
                chk("t6_clr_held", 32'(pin_clr_n), 0);
            end
            if (k == CLR_CYC) begin
                chk("t6_ready_after_clr", 32'(ready), 1);
                chk("t6_clr_released", 32'(pin_clr_n), 1);
            end
        end
        $display("abort: frame=%0d score=%0d ready=%0d", frame, score, ready);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
